bram_req_adapter: RTL and testbench

Valid/ready front-end for the single-port block RAM wrapper (1-cycle read latency, per-byte write enables, read-first). Accepts one read or write request per cycle from a bus master, drives the RAM port, and returns exactly one response per request through a valid/ready channel. A 2-entry response buffer absorbs backpressure so the RAM's fixed latency never loses data.

---
 rtl/bram_pkg.sv | 12 +
 rtl/bram_req_adapter_fifo.sv | 41 ++++
 rtl/bram_req_adapter.sv | 117 +++++++++++
 tb/tb_bram_req_adapter.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/bram_pkg.sv
// Shared constants and helpers for the block-RAM request adapter.
// Optional range checking is enabled with BRAM_ADAPTER_RANGE_CHECK_EN.
package bram_pkg;

  localparam int RESP_DEPTH = 2;
  localparam int OCC_BITS   = $clog2(RESP_DEPTH + 1);

  function automatic logic occ_has_room(input logic [OCC_BITS-1:0] occ);
    return occ < OCC_BITS'(RESP_DEPTH);
  endfunction

endpackage

// File: rtl/bram_req_adapter_fifo.sv
// Two-entry response buffer that catches RAM read data when the consumer stalls.
// The caller guarantees that it never pops when empty and never pushes when full without also popping.
module resp_fifo2
  import bram_pkg::*;
#(
  parameter int width = 33
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                push,
  input  logic                pop,
  input  logic [width-1:0]    din,
  output logic [width-1:0]    dout,
  output logic [OCC_BITS-1:0] count,
  output logic                empty
);

  logic [width-1:0] mem [RESP_DEPTH];
  logic             wr_ptr;
  logic             rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
      for (int i = 0; i < RESP_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + OCC_BITS'(push) - OCC_BITS'(pop);
    end
  end

  assign dout  = mem[rd_ptr];
  assign empty = (count == '0);

endmodule

// File: rtl/bram_req_adapter.sv
// Valid/ready front-end for a 1-cycle-latency, read-first block RAM.
// Define BRAM_ADAPTER_RANGE_CHECK_EN to reject addresses at or above 'words'.
module bram_req_adapter
  import bram_pkg::*;
#(
  parameter  int abits  = 8,
  parameter  int dbytes = 4,
  parameter  int blen   = 8,
  parameter  int words  = 1 << abits,
  localparam int dbits  = dbytes * blen
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [abits-1:0]  req_addr,
  input  logic [dbytes-1:0] req_we,
  input  logic [dbits-1:0]  req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [dbits-1:0]  resp_rdata,
  output logic              resp_err,
  output logic [dbytes-1:0] ram_we,
  output logic [abits-1:0]  ram_addr,
  output logic [dbits-1:0]  ram_wdata,
  input  logic [dbits-1:0]  ram_rdata
);

  typedef struct packed {
    logic [dbits-1:0] rdata;
    logic             err;
  } resp_t;

  logic                alive;
  logic                inflight;
  logic                accept;
  logic                req_err;
  logic                push;
  logic                pop;
  logic                fifo_pop;
  logic                fifo_empty;
  logic [OCC_BITS-1:0] fifo_count;
  logic [OCC_BITS-1:0] occupancy;
  resp_t               bypass;
  resp_t               fifo_head;
  resp_t               head;

`ifdef BRAM_ADAPTER_RANGE_CHECK_EN
  localparam logic [abits:0] words_lim = (abits + 1)'(words);
  logic inflight_err;

  assign req_err = ({1'b0, req_addr} >= words_lim);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) inflight_err <= 1'b0;
    else        inflight_err <= accept && req_err;
  end

  // A rejected request still returns a response in order, just with zero data.
  assign bypass.rdata = inflight_err ? '0 : ram_rdata;
  assign bypass.err   = inflight_err;
`else
  logic unused_words;
  assign unused_words = (words > 0);
  assign req_err      = 1'b0;
  assign bypass.rdata = ram_rdata;
  assign bypass.err   = 1'b0;
`endif

  // alive keeps req_ready low until the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alive    <= 1'b0;
      inflight <= 1'b0;
    end else begin
      alive    <= 1'b1;
      inflight <= accept;
    end
  end

  assign occupancy = OCC_BITS'(inflight) + fifo_count;
  assign req_ready = alive && occ_has_room(occupancy);
  assign accept    = req_valid && req_ready;

  assign ram_addr  = req_addr;
  assign ram_wdata = req_wdata;
  assign ram_we    = (accept && !req_err) ? req_we : '0;

  always_comb begin
    head = '0;
    if (!fifo_empty)   head = fifo_head;
    else if (inflight) head = bypass;
  end

  assign resp_valid = !fifo_empty || inflight;
  assign resp_rdata = head.rdata;
  assign resp_err   = head.err;

  // RAM data lasts one cycle, so an unconsumed in-flight response must be captured now.
  assign pop      = resp_valid && resp_ready;
  assign fifo_pop = pop && !fifo_empty;
  assign push     = inflight && !(fifo_empty && pop);

  resp_fifo2 #(
    .width($bits(resp_t))
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (push),
    .pop  (fifo_pop),
    .din  (bypass),
    .dout (fifo_head),
    .count(fifo_count),
    .empty(fifo_empty)
  );

endmodule

// File: tb/tb_bram_req_adapter.sv
// Randomised and directed bench for bram_req_adapter against a transaction-level model
// (shadow memory plus an ordered queue of expected responses).
module tb_bram_req_adapter;

`ifdef BRAM_ADAPTER_RANGE_CHECK_EN
  localparam int WORDS = 200;
`else
  localparam int WORDS = 256;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [7:0]  req_addr = '0;
  logic [3:0]  req_we = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [3:0]  ram_we;
  logic [7:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  int checks = 0;
  int errors = 0;
  int n_acc = 0;
  int dut_acc = 0;

  logic [31:0] exp_mem [256];
  logic [32:0] rq [$];
  logic        alive = 1'b0;

  logic [31:0] ram [256];
  logic        ram_init = 1'b0;

  always #5 clk = ~clk;

  bram_req_adapter #(
    .abits (8),
    .dbytes(4),
    .blen  (8),
    .words (WORDS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_we    (req_we),
    .req_wdata (req_wdata),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_rdata(resp_rdata),
    .resp_err  (resp_err),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  function automatic logic [31:0] init_word(input int i);
    return (32'h0101_0101 * 32'(i)) ^ 32'h5A00_0000;
  endfunction

  // Read-first single-port RAM with byte enables, as seen by the adapter.
  always @(posedge clk) begin
    if (!ram_init) begin
      for (int i = 0; i < 256; i++) ram[i] <= init_word(i);
      ram_init <= 1'b1;
    end else begin
      ram_rdata <= ram[ram_addr];
      for (int b = 0; b < 4; b++)
        if (ram_we[b]) ram[ram_addr][b*8 +: 8] <= ram_wdata[b*8 +: 8];
    end
  end

  always @(posedge clk)
    if (rst_n && req_valid && req_ready) dut_acc <= dut_acc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%h, expected 0x%h", tag, got, exp);
    end
  endtask

  // One cycle: check registered outputs, drive inputs, check ram_we, advance the model.
  task automatic applyStimulus(input logic v, input logic [7:0] a, input logic [3:0] we,
                               input logic [31:0] wd, input logic rr);
    logic exp_ready, exp_valid, acc, pp, err;
    exp_ready = alive && (rq.size() < 2);
    exp_valid = (rq.size() > 0);
    checkOutput("req_ready", 32'(req_ready), 32'(exp_ready));
    checkOutput("resp_valid", 32'(resp_valid), 32'(exp_valid));
    if (exp_valid) begin
      checkOutput("resp_rdata", resp_rdata, rq[0][31:0]);
      checkOutput("resp_err", 32'(resp_err), 32'(rq[0][32]));
    end
    req_valid  = v;
    req_addr   = a;
    req_we     = we;
    req_wdata  = wd;
    resp_ready = rr;
    #1;
    acc = v && exp_ready;
    pp  = exp_valid && rr;
`ifdef BRAM_ADAPTER_RANGE_CHECK_EN
    err = (int'(a) >= WORDS);
`else
    err = 1'b0;
`endif
    checkOutput("ram_we", 32'(ram_we), (acc && !err) ? 32'(we) : 32'h0);
    if (pp) void'(rq.pop_front());
    if (acc) begin
      rq.push_back({err, err ? 32'h0 : exp_mem[a]});
      if (!err)
        for (int b = 0; b < 4; b++)
          if (we[b]) exp_mem[a][b*8 +: 8] = wd[b*8 +: 8];
      n_acc++;
    end
    alive = 1'b1;
    @(negedge clk);
  endtask

  // Holds reset with whatever inputs the caller left applied, then releases it.
  task automatic doReset(input int cycles);
    rst_n = 1'b0;
    rq.delete();
    alive = 1'b0;
    #1;
    for (int i = 0; i < cycles; i++) begin
      checkOutput("rst_resp_valid", 32'(resp_valid), 32'h0);
      checkOutput("rst_req_ready", 32'(req_ready), 32'h0);
      checkOutput("rst_resp_err", 32'(resp_err), 32'h0);
      checkOutput("rst_resp_rdata", resp_rdata, 32'h0);
      checkOutput("rst_ram_we", 32'(ram_we), 32'h0);
      @(negedge clk);
    end
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation hung");
  end

  initial begin
    int base, idx;
    for (int i = 0; i < 256; i++) exp_mem[i] = init_word(i);
    @(negedge clk);
    doReset(3);

    // Full-word write then read back one cycle after accept.
    applyStimulus(1, 8'd5, 4'hF, 32'hDEADBEEF, 1);
    applyStimulus(1, 8'd5, 4'h0, 32'h0, 1);
    applyStimulus(0, 8'd0, 4'h0, 32'h0, 1);

    // Byte-lane write over a known word.
    applyStimulus(1, 8'd7, 4'hF, 32'h11223344, 1);
    applyStimulus(1, 8'd7, 4'b0010, 32'h0000AA00, 1);
    applyStimulus(1, 8'd7, 4'h0, 32'h0, 1);
    applyStimulus(0, 8'd0, 4'h0, 32'h0, 1);
    applyStimulus(0, 8'd0, 4'h0, 32'h0, 1);

    // Back-to-back reads at full rate.
    base = dut_acc;
    for (int i = 0; i < 16; i++) applyStimulus(1, 8'(i), 4'h0, 32'h0, 1);
    checkOutput("b2b_accepts", 32'(dut_acc - base), 32'd16);
    applyStimulus(0, 8'd0, 4'h0, 32'h0, 1);
    applyStimulus(0, 8'd0, 4'h0, 32'h0, 1);

    // Backpressure: only two requests fit while the consumer stalls.
    base = dut_acc;
    idx = n_acc;
    for (int i = 0; i < 6; i++) applyStimulus(1, 8'(40 + n_acc - idx), 4'h0, 32'h0, 0);
    checkOutput("bp_held", 32'(dut_acc - base), 32'd2);
    for (int i = 0; i < 12; i++)
      applyStimulus((n_acc - idx) < 4, 8'(40 + n_acc - idx), 4'h0, 32'h0, 1);
    checkOutput("bp_accepted", 32'(dut_acc - base), 32'd4);

    // Reset with two responses buffered and a write waiting at the port.
    applyStimulus(1, 8'd20, 4'h0, 32'h0, 0);
    applyStimulus(1, 8'd21, 4'h0, 32'h0, 0);
    applyStimulus(1, 8'd30, 4'hF, 32'hCAFEF00D, 0);
    doReset(3);
    applyStimulus(0, 8'd0, 4'h0, 32'h0, 1);
    applyStimulus(1, 8'd30, 4'h0, 32'h0, 1);
    applyStimulus(0, 8'd0, 4'h0, 32'h0, 1);

    // Address beyond the implemented range (rejected only with the check compiled in).
    applyStimulus(1, 8'd250, 4'h0, 32'h0, 1);
    applyStimulus(1, 8'd250, 4'hF, 32'h12345678, 1);
    applyStimulus(1, 8'd250, 4'h0, 32'h0, 1);
    applyStimulus(0, 8'd0, 4'h0, 32'h0, 1);

    // Random traffic with random consumer stalls.
    for (int i = 0; i < 400; i++)
      applyStimulus($urandom_range(0, 3) != 0, 8'($urandom_range(0, 255)),
                    ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0,
                    32'($urandom), $urandom_range(0, 9) < 7);
    for (int i = 0; i < 6; i++) applyStimulus(0, 8'd0, 4'h0, 32'h0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
